// File: rtl/stump_arb_pkg.sv
// stump_arb_pkg: shared state encoding and width constants for the Stump memory arbiter
package stump_arb_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int WAIT_W = 8;
  typedef enum logic [1:0] {IDLE, PEND, DONE} arb_state_t;
endpackage

// File: rtl/stump_sat_counter.sv
// stump_sat_counter: saturating up-counter with synchronous clear
// Ports: clk, rst (sync, active-high), clr (zero the count), inc (count up, holds at all-ones), count
module stump_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk)
    count <= (rst || clr) ? '0 : (inc && count != '1) ? count + 1'b1 : count;
endmodule

// File: rtl/stump_mem_arbiter.sv
// stump_mem_arbiter: shares one memory port between the Stump CPU (fixed priority) and a secondary requester
// Ports: clk, rst (sync, active-high); cpu_* Stump side; dev_* secondary requester with ack/busy/starvation;
//        wait_count cycles the current request has waited; mem_* shared memory port; stat_* counters.
// Build option: define STUMP_ARB_STATS_EN to build the grant/conflict counters, otherwise they read 0.
module stump_mem_arbiter
  import stump_arb_pkg::*;
#(
  parameter int WAIT_LIMIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_data_out,
  input  logic              cpu_mem_ren,
  input  logic              cpu_mem_wen,
  output logic [DATA_W-1:0] cpu_data_in,
  input  logic              dev_req,
  input  logic              dev_wen,
  input  logic [ADDR_W-1:0] dev_address,
  input  logic [DATA_W-1:0] dev_wdata,
  output logic              dev_ack,
  output logic [DATA_W-1:0] dev_rdata,
  output logic              dev_busy,
  output logic              dev_starved,
  output logic [WAIT_W-1:0] wait_count,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ren,
  output logic              mem_wen,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       stat_dev_grants,
  output logic [15:0]       stat_conflicts
);
  arb_state_t        st;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              lat_wen;
  logic              cpu_act;
  logic              grant;
  logic              conflict;
  assign cpu_act  = cpu_mem_ren | cpu_mem_wen;
  // the latched request owns the port only in a PEND cycle the CPU leaves free
  assign grant    = st == PEND && !cpu_act;
  assign conflict = st == PEND && cpu_act;
  always_comb begin
    mem_address = cpu_act ? cpu_address : grant ? lat_addr : '0;
    mem_wdata   = cpu_act ? cpu_data_out : grant ? lat_wdata : '0;
    mem_ren     = cpu_act ? cpu_mem_ren : grant && !lat_wen;
    mem_wen     = cpu_act ? cpu_mem_wen : grant && lat_wen;
  end
  assign cpu_data_in = mem_rdata;
  assign dev_ack     = st == DONE;
  assign dev_busy    = st != IDLE;
  assign dev_starved = st == PEND && wait_count >= WAIT_W'(WAIT_LIMIT);
  always_ff @(posedge clk)
    if (rst) begin
      st        <= IDLE;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_wen   <= 1'b0;
      dev_rdata <= '0;
    end else
      case (st)
        IDLE: if (dev_req) begin
          st        <= PEND;
          lat_addr  <= dev_address;
          lat_wdata <= dev_wdata;
          lat_wen   <= dev_wen;
        end
        PEND: if (!cpu_act) begin
          st <= DONE;
          if (!lat_wen) dev_rdata <= mem_rdata;
        end
        default: st <= IDLE;
      endcase
  stump_sat_counter #(.W(WAIT_W)) u_wait (
    .clk  (clk),
    .rst  (rst),
    .clr  (st == IDLE && dev_req),
    .inc  (conflict),
    .count(wait_count)
  );
`ifdef STUMP_ARB_STATS_EN
  always_ff @(posedge clk)
    if (rst) begin
      stat_dev_grants <= '0;
      stat_conflicts  <= '0;
    end else begin
      stat_dev_grants <= stat_dev_grants + 16'(grant);
      stat_conflicts  <= stat_conflicts + 16'(conflict);
    end
`else
  assign stat_dev_grants = '0;
  assign stat_conflicts  = '0;
`endif
endmodule

// File: tb/tb_stump_mem_arbiter.sv
// tb_stump_mem_arbiter: directed scoreboard bench for stump_mem_arbiter
module tb_stump_mem_arbiter;
  logic        clk = 0;
  logic        rst;
  logic [15:0] cpu_address, cpu_data_out, cpu_data_in;
  logic        cpu_mem_ren, cpu_mem_wen;
  logic        dev_req, dev_wen, dev_ack, dev_busy, dev_starved;
  logic [15:0] dev_address, dev_wdata, dev_rdata;
  logic [7:0]  wait_count;
  logic [15:0] mem_address, mem_wdata, mem_rdata;
  logic        mem_ren, mem_wen;
  logic [15:0] stat_dev_grants, stat_conflicts;
  logic [15:0] mem [0:65535];
  logic [15:0] exp_q [$];
  int checks = 0, failures = 0, cycn = 0, last_ack = -1, w50 = 0;

  stump_mem_arbiter #(.WAIT_LIMIT(3)) dut (
    .clk(clk), .rst(rst),
    .cpu_address(cpu_address), .cpu_data_out(cpu_data_out),
    .cpu_mem_ren(cpu_mem_ren), .cpu_mem_wen(cpu_mem_wen), .cpu_data_in(cpu_data_in),
    .dev_req(dev_req), .dev_wen(dev_wen), .dev_address(dev_address), .dev_wdata(dev_wdata),
    .dev_ack(dev_ack), .dev_rdata(dev_rdata), .dev_busy(dev_busy), .dev_starved(dev_starved),
    .wait_count(wait_count),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .mem_rdata(mem_rdata),
    .stat_dev_grants(stat_dev_grants), .stat_conflicts(stat_conflicts)
  );

  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_address];

  always @(posedge clk) begin
    cycn <= cycn + 1;
    if (mem_wen && mem_address == 16'h0050) w50 <= w50 + 1;
    if (rst) begin
      mem[16'h0010] <= 16'h5555;
      mem[16'h0020] <= 16'h0000;
      mem[16'h0040] <= 16'hBEEF;
      mem[16'h0050] <= 16'h0000;
      mem[16'h0060] <= 16'h0000;
    end else if (mem_wen) mem[mem_address] <= mem_wdata;
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", n, a, e, $time);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk)
    if (dev_ack) begin
      if (exp_q.size() == 0) chk("ack_unexpected", 1, 0);
      else chk("ack_rdata", dev_rdata, exp_q.pop_front());
      if (last_ack >= 0) chk("ack_gap", cycn - last_ack >= 3, 1);
      last_ack = cycn;
    end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; dev_req = 0; dev_wen = 0; dev_address = 0; dev_wdata = 0;
    cpu_mem_ren = 0; cpu_mem_wen = 0; cpu_address = 0; cpu_data_out = 0;
    cyc; cyc; rst = 0;
    @(negedge clk);
    chk("rst_ack", dev_ack, 0); chk("rst_busy", dev_busy, 0); chk("rst_starved", dev_starved, 0);
    chk("rst_wait", wait_count, 0); chk("rst_rdata", dev_rdata, 0);
    chk("rst_stats", {stat_dev_grants, stat_conflicts}, 0);
    chk("idle_mem", {mem_ren, mem_wen, mem_address, mem_wdata}, 0);

    // minimum-latency read
    dev_req = 1; dev_wen = 0; dev_address = 16'h0040; exp_q.push_back(16'hBEEF);
    cyc; dev_req = 0;
    @(negedge clk);
    chk("rd_access", {mem_ren, mem_wen, mem_address}, {1'b1, 1'b0, 16'h0040});
    chk("rd_busy", dev_busy, 1); chk("rd_ack_early", dev_ack, 0);
    cyc; @(negedge clk); chk("rd_ack", dev_ack, 1);
    cyc; @(negedge clk); chk("rd_done", {dev_ack, dev_busy}, 0); chk("rd_hold", dev_rdata, 16'hBEEF);

    // write pending behind four CPU read cycles
    dev_req = 1; dev_wen = 1; dev_address = 16'h0020; dev_wdata = 16'h1234;
    cyc; dev_req = 0; cpu_mem_ren = 1; cpu_address = 16'h0010;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("cpu_prio", {mem_ren, mem_wen, mem_address}, {1'b1, 1'b0, 16'h0010});
      chk("cpu_data_in", cpu_data_in, 16'h5555);
      chk("wait_inc", wait_count, i);
      cyc;
    end
    cpu_mem_ren = 0; exp_q.push_back(16'hBEEF);
    @(negedge clk);
    chk("wr_wait", wait_count, 4);
    chk("wr_access", {mem_ren, mem_wen, mem_address, mem_wdata}, {1'b0, 1'b1, 16'h0020, 16'h1234});
    cyc; @(negedge clk); chk("wr_ack", dev_ack, 1); chk("wr_starved_done", dev_starved, 0);
    cyc; @(negedge clk); chk("wr_mem", mem[16'h0020], 16'h1234);

    // starvation with WAIT_LIMIT=3
    dev_req = 1; dev_wen = 0; dev_address = 16'h0010; exp_q.push_back(16'h5555);
    cyc; dev_req = 0; cpu_mem_wen = 1; cpu_address = 16'h0030; cpu_data_out = 16'h7777;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("starve_wait", wait_count, i);
      chk("starve_flag", dev_starved, i >= 3);
      cyc;
    end
    cpu_mem_wen = 0;
    @(negedge clk); chk("starve_last", {dev_starved, mem_ren, mem_address}, {1'b1, 1'b1, 16'h0010});
    cyc; @(negedge clk); chk("starve_clear", dev_starved, 0);
    cyc;

    // reset while pending
    dev_req = 1; dev_wen = 1; dev_address = 16'h0050; dev_wdata = 16'hAAAA;
    cyc; dev_req = 0; cpu_mem_ren = 1; cpu_address = 16'h0010; rst = 1;
    @(negedge clk); chk("rstp_nowen", mem_wen, 0);
    cyc; rst = 0; cpu_mem_ren = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rstp_idle", {dev_busy, mem_wen, mem_ren}, 0);
      cyc;
    end
    chk("rstp_nowrite", w50, 0); chk("rstp_rdata", dev_rdata, 0);

    // request held high through DONE
    dev_req = 1; dev_wen = 0; dev_address = 16'h0040;
    exp_q.push_back(16'hBEEF); exp_q.push_back(16'hBEEF);
    cyc; cyc; @(negedge clk); chk("hold_ack1", dev_ack, 1);
    cyc; @(negedge clk); chk("hold_idle", {dev_ack, dev_busy}, 0);
    cyc; @(negedge clk); chk("hold_pend", {dev_ack, dev_busy}, 2'b01);
    dev_req = 0;
    cyc; @(negedge clk); chk("hold_ack2", dev_ack, 1);
    cyc;

    // statistics: two grants, four conflict cycles
    rst = 1; cyc; rst = 0;
    dev_req = 1; dev_wen = 1; dev_address = 16'h0060; dev_wdata = 16'h0C0C; exp_q.push_back(16'h0000);
    cyc; dev_req = 0; cpu_mem_ren = 1; cpu_address = 16'h0010;
    cyc; cyc; cyc; cyc; cpu_mem_ren = 0;
    cyc; cyc;
    dev_req = 1; dev_wen = 0; exp_q.push_back(16'h0C0C);
    cyc; dev_req = 0; cyc; cyc;
    @(negedge clk);
`ifdef STUMP_ARB_STATS_EN
    chk("stat_grants", stat_dev_grants, 2); chk("stat_conflicts", stat_conflicts, 4);
`else
    chk("stat_grants", stat_dev_grants, 0); chk("stat_conflicts", stat_conflicts, 0);
`endif
    cyc; cyc;
    chk("pending_acks", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/stump_mem_arbiter.md
STUMP_MEM_ARBITER -- requirements
Module: stump_mem_arbiter

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 15, meaning the wait-cycle count at or above which dev_starved asserts (range 1..255).
REQ-002 SHALL have clk  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have rst  input  1  master reset, synchronous, active-high.
REQ-004 SHALL have cpu_address  input  16  Stump address; cpu_data_out  input  16  Stump write data.
REQ-005 SHALL have cpu_mem_ren  input  1  and cpu_mem_wen  input  1  Stump read/write enables.
REQ-006 SHALL have cpu_data_in  output  16  read data to Stump.
REQ-007 SHALL have dev_req  input  1  secondary-requester access request; dev_wen  input  1  1=write, 0=read.
REQ-008 SHALL have dev_address  input  16  and dev_wdata  input  16  secondary-requester request fields.
REQ-009 SHALL have dev_ack  output  1  one-cycle completion pulse; dev_rdata  output  16  captured read data.
REQ-010 SHALL have dev_busy  output  1  high while a request is held; dev_starved  output  1  wait limit reached.
REQ-011 SHALL have wait_count  output  8  wait cycles of the current request.
REQ-012 SHALL have mem_address  output  16, mem_wdata  output  16, mem_ren  output  1, mem_wen  output  1, mem_rdata  input  16  shared memory port; read data is combinational within the access cycle.
REQ-013 SHALL have stat_dev_grants  output  16 and stat_conflicts  output  16 statistics counters.

Function
REQ-014 SHALL implement states IDLE, PEND, DONE.
REQ-015 IDLE: dev_req=1 SHALL latch dev_address, dev_wdata and dev_wen, clear wait_count, and go to PEND; dev_req is ignored in PEND and DONE.
REQ-016 CPU priority: when cpu_mem_ren or cpu_mem_wen is 1, the mem_* outputs SHALL equal the cpu_* inputs combinationally in that cycle, in every state.
REQ-017 PEND with the CPU idle (both enables 0): the mem_* outputs SHALL carry the latched request for exactly that cycle; the FSM SHALL capture mem_rdata into dev_rdata on a read and go to DONE.
REQ-018 PEND with the CPU active: the FSM SHALL stay in PEND and wait_count SHALL increment, saturating at 255.
REQ-019 DONE: dev_ack SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE; dev_rdata SHALL hold its value until the next read capture.
REQ-020 Minimum latency: dev_req sampled in IDLE, access in the next cycle, dev_ack one cycle later (three edges total).
REQ-021 cpu_data_in SHALL equal mem_rdata at all times.
REQ-022 With no owner, mem_ren and mem_wen SHALL be 0 and mem_address/mem_wdata SHALL be 0.
REQ-023 dev_busy SHALL be 1 in PEND and DONE; dev_starved SHALL be (wait_count >= WAIT_LIMIT) while in PEND, else 0.
REQ-024 A write request SHALL leave dev_rdata unchanged.

Reset
REQ-025 rst=1 at an edge SHALL force IDLE; wait_count, dev_rdata and the stat counters SHALL go to 0; dev_ack, dev_busy and dev_starved SHALL go to 0.
REQ-026 Reset mid-request SHALL abandon the request: no memory access for it after the reset edge, and no dev_ack.

Configuration
REQ-027 With STUMP_ARB_STATS_EN defined: stat_dev_grants SHALL increment on each PEND->DONE transition; stat_conflicts SHALL increment on each PEND cycle in which the CPU is active; both wrap at 16 bits.
REQ-028 Without STUMP_ARB_STATS_EN: both stat outputs SHALL be constant 0 and no counter logic is built.

Structure
REQ-029 Shared package stump_arb_pkg SHALL hold the state encoding, the 16-bit address/data width constants and the 8-bit wait-counter width.
REQ-030 Sub-module stump_sat_counter (parameterised width, clear, increment, saturate) SHALL implement wait_count.

Verification
REQ-031 dev_req=1 read at 0x0040 with the CPU idle, memory holding 0xBEEF -> mem_ren=1 and mem_address=0x0040 on cycle 2, dev_ack=1 and dev_rdata=0xBEEF on cycle 3.
REQ-032 CPU reads 0x0010 for 4 cycles while a dev write of 0x1234 to 0x0020 is pending -> mem_* show CPU values throughout, wait_count=4, then a single mem_wen cycle at 0x0020 with data 0x1234, then dev_ack.
REQ-033 WAIT_LIMIT=3 with the CPU active for 5 cycles -> dev_starved rises when wait_count=3 and clears on leaving PEND.
REQ-034 rst asserted in PEND -> next cycle IDLE, no mem_wen for the dev request, dev_ack never pulses.
REQ-035 dev_req held high through DONE -> the second request is latched only after the return to IDLE, and dev_ack pulses are separated by at least 2 cycles.
REQ-036 STUMP_ARB_STATS_EN, two grants and 4 conflict cycles -> stat_dev_grants=2 and stat_conflicts=4; without the macro both read 0.
